// File: rtl/fetch_bundle_gen.sv
// fetch_bundle_gen: PC holder and single-outstanding I-cache requester that packs 16-byte lines
// into 4-wide decode bundles. Define FETCH_PREFETCH_EN to add a 1-entry response buffer.
module fetch_bundle_gen #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         icache_req,
  output logic [31:0]  icache_addr,
  input  logic         icache_addr_ok,
  input  logic         icache_data_ok,
  input  logic [127:0] icache_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         next_ready,
  output logic         out_valid,
  output logic [127:0] inst_4W_out,
  output logic [3:0]   inst_4W_valid_out,
  output logic [31:0]  pc_out
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_CANCEL = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [31:0]  pc;
  logic [1:0]   k;
  logic         slot_free;
  logic         req_fire;
  logic         resp_keep;
  logic         out_fire;
  logic [127:0] packed_data;
  logic [3:0]   packed_mask;
  logic [31:0]  w0, w1, w2, w3;

  // pc is frozen between the address handshake and data_ok, so it doubles as the latched request pc
  assign k           = pc[3:2];
  assign icache_addr = {pc[31:4], 4'b0000};
  assign req_fire    = icache_req & icache_addr_ok;
  assign resp_keep   = (state == S_WAIT) & icache_data_ok & ~redirect_valid;
  assign out_fire    = out_valid & next_ready;
  assign icache_req  = ~rst & (state == S_REQ) & slot_free;

  assign w0 = icache_rdata[31:0];
  assign w1 = icache_rdata[63:32];
  assign w2 = icache_rdata[95:64];
  assign w3 = icache_rdata[127:96];

  always_comb begin
    packed_data = '0;
    unique case (k)
      2'd0:    packed_data = {w0, w1, w2, w3};
      2'd1:    packed_data = {w1, w2, w3, 32'h0};
      2'd2:    packed_data = {w2, w3, 64'h0};
      default: packed_data = {w3, 96'h0};
    endcase
  end

  assign packed_mask = 4'b1111 << k;

  // A response in CANCEL always returns to REQ, even under a fresh redirect: the orphan is gone
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (req_fire) state_nxt = redirect_valid ? S_CANCEL : S_WAIT;
      end
      S_WAIT: begin
        if (icache_data_ok)      state_nxt = S_REQ;
        else if (redirect_valid) state_nxt = S_CANCEL;
      end
      S_CANCEL: begin
        if (icache_data_ok) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid)
        pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (resp_keep)
        pc <= {pc[31:4] + 28'd1, 4'b0000};
    end
  end

`ifdef FETCH_PREFETCH_EN
  logic         buf_valid;
  logic [127:0] buf_data;
  logic [3:0]   buf_mask;
  logic [31:0]  buf_pc;

  assign slot_free = ~buf_valid;

  // Requests only issue with the buffer empty, so a kept response never meets a full buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      inst_4W_out       <= '0;
      inst_4W_valid_out <= '0;
      pc_out            <= '0;
      buf_valid         <= 1'b0;
      buf_data          <= '0;
      buf_mask          <= '0;
      buf_pc            <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      buf_valid <= 1'b0;
    end else if (resp_keep && out_valid && !next_ready) begin
      buf_valid <= 1'b1;
      buf_data  <= packed_data;
      buf_mask  <= packed_mask;
      buf_pc    <= pc;
    end else if (resp_keep) begin
      out_valid         <= 1'b1;
      inst_4W_out       <= packed_data;
      inst_4W_valid_out <= packed_mask;
      pc_out            <= pc;
    end else if (out_fire && buf_valid) begin
      out_valid         <= 1'b1;
      inst_4W_out       <= buf_data;
      inst_4W_valid_out <= buf_mask;
      pc_out            <= buf_pc;
      buf_valid         <= 1'b0;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign slot_free = ~out_valid | next_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      inst_4W_out       <= '0;
      inst_4W_valid_out <= '0;
      pc_out            <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (resp_keep) begin
      out_valid         <= 1'b1;
      inst_4W_out       <= packed_data;
      inst_4W_valid_out <= packed_mask;
      pc_out            <= pc;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_bundle_gen.sv
// Directed self-checking bench for fetch_bundle_gen (default build, no prefetch buffer).
module tb_fetch_bundle_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_req;
  logic [31:0]  icache_addr;
  logic         icache_addr_ok;
  logic         icache_data_ok;
  logic [127:0] icache_rdata;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         next_ready;
  logic         out_valid;
  logic [127:0] inst_4W_out;
  logic [3:0]   inst_4W_valid_out;
  logic [31:0]  pc_out;

  int checks   = 0;
  int failures = 0;

  fetch_bundle_gen #(.RESET_PC(32'h1c00_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .icache_addr_ok    (icache_addr_ok),
    .icache_data_ok    (icache_data_ok),
    .icache_rdata      (icache_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .next_ready        (next_ready),
    .out_valid         (out_valid),
    .inst_4W_out       (inst_4W_out),
    .inst_4W_valid_out (inst_4W_valid_out),
    .pc_out            (pc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One address handshake followed by a 1-cycle response carrying line
  task automatic do_fetch(input logic [127:0] line);
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = line;
    tick();
    icache_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; icache_addr_ok = 0; icache_data_ok = 0; icache_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; next_ready = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (inst_4W_out !== 128'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst_4W_out); end
    checks++; if (inst_4W_valid_out !== 4'h0) begin failures++; $display("FAIL rst_mask got=%b exp=0000", inst_4W_valid_out); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=0", pc_out); end
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", icache_req); end
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%0b exp=1", icache_req); end
    checks++; if (icache_addr !== 32'h1c00_0000) begin failures++; $display("FAIL rst_first_addr got=%h exp=1c000000", icache_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [127:0] exp_inst;
    for (int unsigned i = 0; i < 3; i++) begin
      exp_addr = 32'h1c00_0000 + 32'(i * 16);
      checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL seq%0d_req got=%0b exp=1", i, icache_req); end
      checks++; if (icache_addr !== exp_addr) begin failures++; $display("FAIL seq%0d_addr got=%h exp=%h", i, icache_addr, exp_addr); end
      do_fetch({32'hA003_0000 + i, 32'hA002_0000 + i, 32'hA001_0000 + i, 32'hA000_0000 + i});
      exp_inst = {32'hA000_0000 + i, 32'hA001_0000 + i, 32'hA002_0000 + i, 32'hA003_0000 + i};
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL seq%0d_valid got=%0b exp=1", i, out_valid); end
      checks++; if (inst_4W_out !== exp_inst) begin failures++; $display("FAIL seq%0d_inst got=%h exp=%h", i, inst_4W_out, exp_inst); end
      checks++; if (inst_4W_valid_out !== 4'b1111) begin failures++; $display("FAIL seq%0d_mask got=%b exp=1111", i, inst_4W_valid_out); end
      checks++; if (pc_out !== exp_addr) begin failures++; $display("FAIL seq%0d_pc_out got=%h exp=%h", i, pc_out, exp_addr); end
    end
  endtask

  task automatic test_redirect_align();
    logic [127:0] line;
    line = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    // k=2
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0108;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ra_flush_valid got=%0b exp=0", out_valid); end
    checks++; if (icache_addr !== 32'h1c00_0100) begin failures++; $display("FAIL ra_k2_addr got=%h exp=1c000100", icache_addr); end
    do_fetch(line);
    checks++; if (inst_4W_out !== {32'h3333_3333, 32'h4444_4444, 64'h0}) begin failures++; $display("FAIL ra_k2_inst got=%h exp=%h", inst_4W_out, {32'h3333_3333, 32'h4444_4444, 64'h0}); end
    checks++; if (inst_4W_valid_out !== 4'b1100) begin failures++; $display("FAIL ra_k2_mask got=%b exp=1100", inst_4W_valid_out); end
    checks++; if (pc_out !== 32'h1c00_0108) begin failures++; $display("FAIL ra_k2_pc_out got=%h exp=1c000108", pc_out); end
    checks++; if (icache_addr !== 32'h1c00_0110) begin failures++; $display("FAIL ra_k2_next_addr got=%h exp=1c000110", icache_addr); end
    // k=3, low bits set and ignored
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_020F;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (icache_addr !== 32'h1c00_0200) begin failures++; $display("FAIL ra_k3_addr got=%h exp=1c000200", icache_addr); end
    do_fetch(line);
    checks++; if (inst_4W_out !== {32'h4444_4444, 96'h0}) begin failures++; $display("FAIL ra_k3_inst got=%h exp=%h", inst_4W_out, {32'h4444_4444, 96'h0}); end
    checks++; if (inst_4W_valid_out !== 4'b1000) begin failures++; $display("FAIL ra_k3_mask got=%b exp=1000", inst_4W_valid_out); end
    checks++; if (pc_out !== 32'h1c00_020C) begin failures++; $display("FAIL ra_k3_pc_out got=%h exp=1c00020c", pc_out); end
    // k=1
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0305;
    tick();
    redirect_valid = 1'b0;
    #1;
    do_fetch(line);
    checks++; if (inst_4W_out !== {32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0}) begin failures++; $display("FAIL ra_k1_inst got=%h", inst_4W_out); end
    checks++; if (inst_4W_valid_out !== 4'b1110) begin failures++; $display("FAIL ra_k1_mask got=%b exp=1110", inst_4W_valid_out); end
    checks++; if (pc_out !== 32'h1c00_0304) begin failures++; $display("FAIL ra_k1_pc_out got=%h exp=1c000304", pc_out); end
    checks++; if (icache_addr !== 32'h1c00_0310) begin failures++; $display("FAIL ra_k1_next_addr got=%h exp=1c000310", icache_addr); end
  endtask

  task automatic test_redirect_in_wait();
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0400;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rw_cancel_req got=%0b exp=0", icache_req); end
    tick();
    tick();
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rw_cancel_req_late got=%0b exp=0", icache_req); end
    icache_data_ok = 1'b1; icache_rdata = {4{32'hDEAD_BEEF}};
    tick();
    icache_data_ok = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_valid got=%0b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL rw_restart_req got=%0b exp=1", icache_req); end
    checks++; if (icache_addr !== 32'h1c00_0400) begin failures++; $display("FAIL rw_restart_addr got=%h exp=1c000400", icache_addr); end
    do_fetch({32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0});
    checks++; if (inst_4W_out !== {32'hB0B0_B0B0, 32'hB1B1_B1B1, 32'hB2B2_B2B2, 32'hB3B3_B3B3}) begin failures++; $display("FAIL rw_inst got=%h", inst_4W_out); end
    checks++; if (pc_out !== 32'h1c00_0400) begin failures++; $display("FAIL rw_pc_out got=%h exp=1c000400", pc_out); end
  endtask

  task automatic test_stall();
    logic [127:0] exp1;
    exp1 = {32'hC0C0_C0C0, 32'hC1C1_C1C1, 32'hC2C2_C2C2, 32'hC3C3_C3C3};
    do_fetch({32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0});
    next_ready = 1'b0;
    icache_addr_ok = 1'b1;
    #1;
    for (int unsigned c = 0; c < 10; c++) begin
      checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL st%0d_req got=%0b exp=0", c, icache_req); end
      checks++; if (out_valid !== 1'b1 || inst_4W_out !== exp1 || pc_out !== 32'h1c00_0410 || inst_4W_valid_out !== 4'b1111) begin
        failures++; $display("FAIL st%0d_hold got=%0b/%h/%h/%b exp=1/%h/1c000410/1111", c, out_valid, inst_4W_out, pc_out, inst_4W_valid_out, exp1);
      end
      tick();
    end
    icache_addr_ok = 1'b0;
    next_ready = 1'b1;
    #1;
    checks++; if (icache_req !== 1'b1) begin failures++; $display("FAIL st_release_req got=%0b exp=1", icache_req); end
    checks++; if (icache_addr !== 32'h1c00_0420) begin failures++; $display("FAIL st_release_addr got=%h exp=1c000420", icache_addr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL st_drain_valid got=%0b exp=0", out_valid); end
    do_fetch({32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0});
    checks++; if (inst_4W_out !== {32'hD0D0_D0D0, 32'hD1D1_D1D1, 32'hD2D2_D2D2, 32'hD3D3_D3D3}) begin failures++; $display("FAIL st_next_inst got=%h", inst_4W_out); end
    checks++; if (pc_out !== 32'h1c00_0420) begin failures++; $display("FAIL st_next_pc_out got=%h exp=1c000420", pc_out); end
  endtask

  task automatic test_redirect_coincident();
    // redirect together with data_ok in WAIT
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1; icache_rdata = {4{32'hBAD0_BAD0}};
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0800;
    tick();
    icache_data_ok = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rc_data_valid got=%0b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h1c00_0800) begin failures++; $display("FAIL rc_data_restart got=%0b/%h exp=1/1c000800", icache_req, icache_addr); end
    do_fetch({4{32'hE0E0_E0E0}});
    checks++; if (pc_out !== 32'h1c00_0800 || inst_4W_out !== {4{32'hE0E0_E0E0}}) begin failures++; $display("FAIL rc_data_bundle got=%h/%h exp=1c000800/%h", pc_out, inst_4W_out, {4{32'hE0E0_E0E0}}); end
    // redirect together with addr_ok in REQ
    icache_addr_ok = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0900;
    tick();
    icache_addr_ok = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL rc_addr_cancel_req got=%0b exp=0", icache_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rc_addr_valid got=%0b exp=0", out_valid); end
    icache_data_ok = 1'b1; icache_rdata = {4{32'hBAD1_BAD1}};
    tick();
    icache_data_ok = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rc_orphan_valid got=%0b exp=0", out_valid); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h1c00_0900) begin failures++; $display("FAIL rc_addr_restart got=%0b/%h exp=1/1c000900", icache_req, icache_addr); end
    do_fetch({4{32'hF0F0_F0F0}});
    checks++; if (pc_out !== 32'h1c00_0900 || inst_4W_out !== {4{32'hF0F0_F0F0}}) begin failures++; $display("FAIL rc_addr_bundle got=%h/%h exp=1c000900/%h", pc_out, inst_4W_out, {4{32'hF0F0_F0F0}}); end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (icache_addr !== 32'hFFFF_FFF0) begin failures++; $display("FAIL wr_top_addr got=%h exp=fffffff0", icache_addr); end
    do_fetch({32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001});
    checks++; if (pc_out !== 32'hFFFF_FFF0) begin failures++; $display("FAIL wr_top_pc_out got=%h exp=fffffff0", pc_out); end
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0000_0000) begin failures++; $display("FAIL wr_wrap_addr got=%0b/%h exp=1/00000000", icache_req, icache_addr); end
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || icache_req !== 1'b0) begin failures++; $display("FAIL wr_rst_ctl got=%0b/%0b exp=0/0", out_valid, icache_req); end
    checks++; if (inst_4W_out !== 128'h0 || inst_4W_valid_out !== 4'h0 || pc_out !== 32'h0) begin failures++; $display("FAIL wr_rst_data got=%h/%b/%h exp=0/0000/0", inst_4W_out, inst_4W_valid_out, pc_out); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h1c00_0000) begin failures++; $display("FAIL wr_rst_restart got=%0b/%h exp=1/1c000000", icache_req, icache_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_align();
    test_redirect_in_wait();
    test_stall();
    test_redirect_coincident();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
